// File: rtl/adder4_sum_accumulator.sv
// rtl/adder4_sum_accumulator.sv - accumulates N 5-bit adder results into a wide total with sticky overflow
module adder4_sum_accumulator #(
    parameter int ACC_W = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [3:0]       s_in,
    input  logic             c4_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CNT_W-1:0] num_samples,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] n_lat;
    logic [CNT_W-1:0] n_first;
    logic [CNT_W-1:0] cnt_next;
    logic [ACC_W:0]   sample;
    logic [ACC_W:0]   sum;
    logic             accept;

    // in_ready depends only on state and clear so no in_valid->in_ready loop exists
    assign in_ready = (state != DONE) && !clear;
    assign accept   = in_valid && in_ready;

    assign sample   = {{(ACC_W-4){1'b0}}, c4_in, s_in};
    assign sum      = {1'b0, acc_out} + sample;
    assign n_first  = (num_samples == '0) ? CNT_ONE : num_samples;
    assign cnt_next = cnt + CNT_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc_out   <= '0;
            acc_ovf   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
            n_lat     <= '0;
        end else if (clear) begin
            state     <= IDLE;
            acc_out   <= '0;
            acc_ovf   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc_out <= sample[ACC_W-1:0];
                        acc_ovf <= 1'b0;
                        cnt     <= CNT_ONE;
                        n_lat   <= n_first;
                        if (n_first == CNT_ONE) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                            busy  <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_out <= sum[ACC_W-1:0];
                        acc_ovf <= acc_ovf | sum[ACC_W];
                        cnt     <= cnt_next;
                        if (cnt_next == n_lat) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    // total stays on acc_out/acc_ovf after the handshake until the next frame starts
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder4_sum_accumulator.sv
// tb/tb_adder4_sum_accumulator.sv - directed self-checking bench for adder4_sum_accumulator
module tb_adder4_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic [3:0] s_in;
    logic       c4_in;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] num_samples;
    logic [7:0] acc_out;
    logic       acc_ovf;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    adder4_sum_accumulator #(.ACC_W(8), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .s_in        (s_in),
        .c4_in       (c4_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .num_samples (num_samples),
        .acc_out     (acc_out),
        .acc_ovf     (acc_ovf),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [4:0] v);
        in_valid = 1'b1;
        {c4_in, s_in} = v;
    endtask

    task automatic handshake();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; s_in = 4'h0; c4_in = 1'b0; in_valid = 1'b0;
        num_samples = 4'd0; out_ready = 1'b0;
        tick();
        chk("reset_acc", acc_out, 8'h00);
        chk("reset_valid", out_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_ovf", acc_ovf, 1'b0);
        rst = 1'b0;
        tick();
        chk("idle_in_ready", in_ready, 1'b1);

        // 3-sample frame
        num_samples = 4'd3;
        offer(5'h05); tick();
        chk("f3_busy1", busy, 1'b1);
        chk("f3_acc1", acc_out, 8'h05);
        offer(5'h1F); tick();
        chk("f3_acc2", acc_out, 8'h24);
        chk("f3_valid2", out_valid, 1'b0);
        offer(5'h0A); tick();
        chk("f3_valid", out_valid, 1'b1);
        chk("f3_acc", acc_out, 8'h2E);
        chk("f3_ovf", acc_ovf, 1'b0);
        chk("f3_busy_done", busy, 1'b0);
        chk("f3_in_ready_done", in_ready, 1'b0);
        in_valid = 1'b0; tick();
        chk("f3_valid_hold", out_valid, 1'b1);
        handshake();
        chk("f3_valid_drop", out_valid, 1'b0);
        chk("f3_in_ready_back", in_ready, 1'b1);
        chk("f3_acc_kept", acc_out, 8'h2E);

        // overflow: 10 x 31 = 310 -> 0x36 with overflow
        num_samples = 4'd10;
        for (int i = 0; i < 10; i++) begin
            offer(5'h1F); tick();
        end
        chk("ovf_valid", out_valid, 1'b1);
        chk("ovf_acc", acc_out, 8'h36);
        chk("ovf_flag", acc_ovf, 1'b1);
        handshake();
        num_samples = 4'd2;
        offer(5'h01); tick();
        chk("ovf_next_flag_cleared", acc_ovf, 1'b0);
        chk("ovf_next_acc1", acc_out, 8'h01);
        offer(5'h01); tick();
        chk("ovf_next_acc", acc_out, 8'h02);
        chk("ovf_next_flag", acc_ovf, 1'b0);
        chk("ovf_next_valid", out_valid, 1'b1);
        handshake();

        // single-sample frames, N=1 and N=0
        num_samples = 4'd1;
        offer(5'h11); tick();
        chk("n1_valid", out_valid, 1'b1);
        chk("n1_acc", acc_out, 8'h11);
        chk("n1_busy", busy, 1'b0);
        handshake();
        num_samples = 4'd0;
        offer(5'h11); tick();
        chk("n0_valid", out_valid, 1'b1);
        chk("n0_acc", acc_out, 8'h11);
        chk("n0_busy", busy, 1'b0);
        handshake();

        // gaps in in_valid, then output stall
        num_samples = 4'd4;
        offer(5'h01); tick();
        num_samples = 4'd1;
        in_valid = 1'b0; s_in = 4'h7; tick();
        chk("gap_hold_acc", acc_out, 8'h01);
        chk("gap_busy", busy, 1'b1);
        offer(5'h02); tick();
        in_valid = 1'b0; tick();
        offer(5'h03); tick();
        chk("gap_acc3", acc_out, 8'h06);
        chk("gap_not_done", out_valid, 1'b0);
        offer(5'h04); tick();
        chk("gap_valid", out_valid, 1'b1);
        chk("gap_acc", acc_out, 8'h0A);
        offer(5'h05);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_acc", acc_out, 8'h0A);
            chk("stall_in_ready", in_ready, 1'b0);
        end
        handshake();
        chk("stall_after_acc", acc_out, 8'h0A);
        chk("stall_after_valid", out_valid, 1'b0);

        // clear during ACCUM
        num_samples = 4'd5;
        offer(5'h0A); tick();
        offer(5'h0A); tick();
        chk("clr_acc_pre", acc_out, 8'h14);
        clear = 1'b1; offer(5'h03); #1;
        chk("clr_in_ready", in_ready, 1'b0);
        tick();
        clear = 1'b0; in_valid = 1'b0; #1;
        chk("clr_acc", acc_out, 8'h00);
        chk("clr_busy", busy, 1'b0);
        chk("clr_valid", out_valid, 1'b0);
        chk("clr_idle_ready", in_ready, 1'b1);
        num_samples = 4'd1;
        offer(5'h04); tick();
        chk("clr_next_acc", acc_out, 8'h04);
        chk("clr_next_valid", out_valid, 1'b1);
        handshake();

        // clear during DONE
        offer(5'h07); tick();
        chk("clrd_valid_pre", out_valid, 1'b1);
        clear = 1'b1; offer(5'h09); #1;
        chk("clrd_in_ready", in_ready, 1'b0);
        tick();
        clear = 1'b0; in_valid = 1'b0; #1;
        chk("clrd_valid", out_valid, 1'b0);
        chk("clrd_acc", acc_out, 8'h00);
        chk("clrd_ready", in_ready, 1'b1);
        offer(5'h02); tick();
        chk("clrd_next_acc", acc_out, 8'h02);
        handshake();

        // async reset mid-frame
        num_samples = 4'd4;
        offer(5'h1F); tick();
        offer(5'h04); tick();
        chk("rst_acc_pre", acc_out, 8'h23);
        chk("rst_busy_pre", busy, 1'b1);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_async_acc", acc_out, 8'h00);
        chk("rst_async_valid", out_valid, 1'b0);
        chk("rst_async_busy", busy, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk("rst_release_ready", in_ready, 1'b1);
        chk("rst_release_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
